// File: rtl/fare_change_engine.sv
// fare_change_engine: latches a purchase, computes fare and change (or refund), dispenses coins over valid/ready.
module fare_change_engine #(
    parameter int PRICE_W  = 4,
    parameter int QTY_W    = 2,
    parameter int PAY_W    = 5,
    parameter int COIN_BIG = 5,
    parameter int DISP_W   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     use_fixed,
    input  logic [PRICE_W-1:0]       ticket_price,
    input  logic [PRICE_W-1:0]       unit_price,
    input  logic [QTY_W-1:0]         amount,
    input  logic [PAY_W-1:0]         real_pay,
    input  logic                     coin_ready,
    output logic [PRICE_W+QTY_W-1:0] total,
    output logic [PAY_W-1:0]         change,
    output logic                     insufficient,
    output logic                     coin_valid,
    output logic                     coin_big,
    output logic [PAY_W-1:0]         big_cnt,
    output logic [PAY_W-1:0]         small_cnt,
    output logic                     busy,
    output logic                     done,
    output logic [DISP_W-1:0]        dispdata
);
    localparam int TW = PRICE_W + QTY_W;
    localparam int CW = (PAY_W > TW) ? PAY_W : TW;
    localparam logic [PAY_W-1:0] BIG = PAY_W'(COIN_BIG);

    typedef enum logic [2:0] {IDLE, CALC, CHECK, DISP, DONE} state_t;

    state_t             state_q, state_d;
    logic               fixed_q, fixed_d;
    logic [PRICE_W-1:0] tprice_q, tprice_d, uprice_q, uprice_d;
    logic [QTY_W-1:0]   amount_q, amount_d;
    logic [PAY_W-1:0]   pay_q, pay_d;
    logic [TW-1:0]      total_q, total_d;
    logic [PAY_W-1:0]   change_q, change_d, rem_q, rem_d;
    logic               insuf_q, insuf_d;
    logic [PAY_W-1:0]   big_q, big_d, small_q, small_d;
    logic [CW-1:0]      pay_x, tot_x;
    logic [PAY_W-1:0]   result;
    logic               use_big;

    always_comb begin
        state_d  = state_q;
        fixed_d  = fixed_q;
        tprice_d = tprice_q;
        uprice_d = uprice_q;
        amount_d = amount_q;
        pay_d    = pay_q;
        total_d  = total_q;
        change_d = change_q;
        rem_d    = rem_q;
        insuf_d  = insuf_q;
        big_d    = big_q;
        small_d  = small_q;
        pay_x    = CW'(pay_q);
        tot_x    = CW'(total_q);
        result   = (pay_x < tot_x) ? pay_q : PAY_W'(pay_x - tot_x);
        use_big  = rem_q >= BIG;
        case (state_q)
            IDLE: if (start) begin
                fixed_d  = use_fixed;
                tprice_d = ticket_price;
                uprice_d = unit_price;
                amount_d = amount;
                pay_d    = real_pay;
                big_d    = '0;
                small_d  = '0;
                insuf_d  = 1'b0;
                state_d  = CALC;
            end
            CALC: begin
                total_d = TW'(fixed_q ? tprice_q : uprice_q) * TW'(amount_q);
                state_d = CHECK;
            end
            CHECK: begin
                insuf_d  = pay_x < tot_x;
                change_d = result;
                rem_d    = result;
                state_d  = (result == '0) ? DONE : DISP;
            end
            DISP: if (coin_ready) begin
                rem_d   = rem_q - (use_big ? BIG : PAY_W'(1));
                big_d   = use_big ? big_q + PAY_W'(1) : big_q;
                small_d = use_big ? small_q : small_q + PAY_W'(1);
                state_d = (rem_d == '0) ? DONE : DISP;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            fixed_q  <= 1'b0;
            tprice_q <= '0;
            uprice_q <= '0;
            amount_q <= '0;
            pay_q    <= '0;
            total_q  <= '0;
            change_q <= '0;
            rem_q    <= '0;
            insuf_q  <= 1'b0;
            big_q    <= '0;
            small_q  <= '0;
        end else begin
            state_q  <= state_d;
            fixed_q  <= fixed_d;
            tprice_q <= tprice_d;
            uprice_q <= uprice_d;
            amount_q <= amount_d;
            pay_q    <= pay_d;
            total_q  <= total_d;
            change_q <= change_d;
            rem_q    <= rem_d;
            insuf_q  <= insuf_d;
            big_q    <= big_d;
            small_q  <= small_d;
        end
    end

    assign total        = total_q;
    assign change       = change_q;
    assign insufficient = insuf_q;
    assign coin_valid   = state_q == DISP;
    assign coin_big     = coin_valid && use_big;
    assign big_cnt      = big_q;
    assign small_cnt    = small_q;
    assign busy         = state_q != IDLE;
    assign done         = state_q == DONE;
    assign dispdata     = DISP_W'(change_q);
endmodule

// File: doc/fare_change_engine.md
# fare_change_engine

Parametrised fare/change engine for the ticket vending datapath, successor to the single-cycle change computation. On a `start` request it latches the purchase (price source, unit price, ticket count, money inserted) and computes the total fare. It then either computes the change or flags an underpayment and refunds the full payment. Finally it dispenses the result as a sequence of large/small coin requests over a valid/ready handshake, and reports completion to the top-level state machine.

## Interface
- `PRICE_W`, 4: width of price inputs.
- `QTY_W`, 2: width of ticket count.
- `PAY_W`, 5: width of inserted money, change and refund.
- `COIN_BIG`, 5: value of the large coin; the small coin value is fixed at 1. Legal range is 2 to 2^PAY_W-1.
- `DISP_W`, 32: width of the display bus.
- `clk` in 1: single system clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `use_fixed` in 1: 1 = use `ticket_price`; 0 = use `unit_price`.
- `ticket_price` in PRICE_W: fixed per-ticket fare.
- `unit_price` in PRICE_W: station-dependent per-ticket fare.
- `amount` in QTY_W: ticket count.
- `real_pay` in PAY_W: money inserted.
- `coin_ready` in 1: coin hopper accepts the current coin.
- `total` out PRICE_W+QTY_W: registered fare.
- `change` out PAY_W: registered change, or refund when underpaid.
- `insufficient` out 1: the payment was less than the fare.
- `coin_valid` out 1: a coin request is presented.
- `coin_big` out 1: 1 = large coin, 0 = small coin; meaningful only while `coin_valid` is 1.
- `big_cnt`, `small_cnt` out PAY_W each: coins accepted in the current transaction.
- `busy` out 1: the state is not IDLE.
- `done` out 1: one-cycle completion pulse.
- `dispdata` out DISP_W: `change` zero-extended.

## Operation
- States: IDLE, CALC, CHECK, DISP, DONE. Encoding is free.
- IDLE:
  - On `start`=1, latch `use_fixed`, `ticket_price`, `unit_price`, `amount` and `real_pay`.
  - Clear `big_cnt`, `small_cnt` and `insufficient`.
  - Go to CALC.
- CALC: `total` <= (latched fixed ? `ticket_price` : `unit_price`) * `amount`. The product is exact at PRICE_W+QTY_W bits. Go to CHECK.
- CHECK: compare `real_pay` and `total`, both zero-extended to max(PAY_W, PRICE_W+QTY_W).
  - If `real_pay` < `total`: `insufficient` <= 1 and `change` <= `real_pay`.
  - Otherwise: `change` <= `real_pay` - `total`. The result always fits in PAY_W.
  - Load the internal `remaining` register with the same value as `change`.
  - Go to DONE if that value is 0, else go to DISP.
- DISP:
  - `coin_valid` = 1.
  - `coin_big` = (`remaining` >= COIN_BIG), decoded from the registered `remaining`.
  - On `coin_valid` & `coin_ready`: subtract COIN_BIG or 1 from `remaining`, and increment `big_cnt` or `small_cnt` accordingly.
  - When the updated `remaining` is 0, go to DONE.
  - With `coin_ready`=0, hold all state; `coin_big` is stable while `coin_valid` is asserted.
- DONE: `done` = 1 for exactly this cycle, then go to IDLE.
- Output retention: `total`, `change`, `insufficient`, the counters and `dispdata` hold until the next accepted `start` or until reset.
- `start` while `busy`=1 is ignored, with no queuing.
- Inputs other than `coin_ready` are don't-care after the latch edge.
- `rst` (any state, including mid-DISP): next state is IDLE and all registers and outputs go to 0. Partially dispensed coins are not tracked.

## Timing
- Edge E0 accepts `start`. After E0 the state is CALC; after E1 it is CHECK, with `total` valid.
- After E2, `change` and `insufficient` are valid, and the state is DISP or DONE.
- Zero change: `done` is high in the cycle after E2, with `busy` high from the cycle after E0 through that cycle. That is 3 cycles from `start` to `done`, with no `coin_valid`.
- Nonzero change: the first `coin_valid` appears in the cycle after E2. Each accepted coin takes at least 1 cycle. `done` is high in the cycle after the last handshake.
- Back-to-back use: `start` in the cycle after `done` is accepted, because the state is IDLE by then.
- `coin_valid`, `coin_big`, `busy` and `done` are decoded from registered state only, with no combinational path from inputs. `coin_valid` may be asserted while `coin_ready` is low.

## Test plan
- Change dispensing: `use_fixed`=0, `unit_price`=3, `amount`=2, `real_pay`=20, `coin_ready`=1, COIN_BIG=5 -> `total`=6, `change`=14, `insufficient`=0. Coins are big, big, small ×4; `big_cnt`=2, `small_cnt`=4; `done` comes 3+6 cycles after `start`. `dispdata`=14.
- Exact payment, fixed price: `use_fixed`=1, `ticket_price`=7, `amount`=3, `real_pay`=21 -> `total`=21, `change`=0, no `coin_valid`, `done` 3 cycles after `start`.
- Underpayment: `unit_price`=4, `amount`=3, `real_pay`=10 -> `total`=12, `insufficient`=1, `change`=10, two big coins, `done`.
- Backpressure: scenario 1 with `coin_ready` toggling 0/1 -> `remaining`, `coin_big` and the counters hold while ready is 0. Results match scenario 1.
- Robustness, busy start: pulse `start` with new inputs during DISP -> ignored, results unchanged.
- Robustness, reset: assert `rst` for 1 cycle mid-DISP -> next cycle all outputs are 0 and the state is IDLE. A fresh `start` then completes normally.
